// File: rtl/agc_pkg.sv
// agc_pkg: shared state encoding and elaboration-time helpers for the AGC
// gain controller (agc_gain_ctrl, agc_sat_step).
package agc_pkg;

    typedef enum logic [1:0] {
        ST_TRACK  = 2'd0,
        ST_ATTACK = 2'd1,
        ST_HOLD   = 2'd2
    } agc_state_t;

    localparam int CLIP_CNT_W = 16;

    // Upper dead-band edge; caller guarantees no overflow at NBITS.
    function automatic logic [31:0] band_hi(input logic [31:0] target,
                                            input logic [31:0] hyst);
        return target + hyst;
    endfunction

    // Lower dead-band edge; caller guarantees target >= hyst.
    function automatic logic [31:0] band_lo(input logic [31:0] target,
                                            input logic [31:0] hyst);
        return target - hyst;
    endfunction

    // The unused encoding 3 behaves as TRACK.
    function automatic agc_state_t decode_state(input logic [1:0] raw);
        case (raw)
            2'd1:    return ST_ATTACK;
            2'd2:    return ST_HOLD;
            default: return ST_TRACK;
        endcase
    endfunction

endpackage

// File: rtl/agc_sat_step.sv
// agc_sat_step: combinational gain +/- step with saturation to [GMIN, GMAX].
// Arithmetic is one bit wider than the gain so carry/borrow is visible and
// the result never wraps.
module agc_sat_step #(
    parameter int               GBITS = 8,
    parameter logic [GBITS-1:0] GMIN  = '0,
    parameter logic [GBITS-1:0] GMAX  = '1
) (
    input  logic [GBITS-1:0] gain,
    input  logic [GBITS-1:0] step,
    input  logic             up,
    output logic [GBITS-1:0] result
);

    logic [GBITS:0] ext;

    // Widened add/sub, then clamp on carry/borrow or limit excursion.
    always_comb begin
        ext    = up ? ({1'b0, gain} + {1'b0, step}) : ({1'b0, gain} - {1'b0, step});
        result = ext[GBITS-1:0];
        if (ext[GBITS]) begin
            result = up ? GMAX : GMIN;
        end else if (ext[GBITS-1:0] > GMAX) begin
            result = GMAX;
        end else if (ext[GBITS-1:0] < GMIN) begin
            result = GMIN;
        end
    end

endmodule

// File: rtl/agc_gain_ctrl.sv
// agc_gain_ctrl: closed-loop gain controller. Fast attack on clip, hold-off
// for HOLD_COUNT strobes, then slow tracking toward the TARGET window.
// Optional build macro AGC_CLIP_COUNT_EN adds a saturating clip_count output.
//
// state  | meaning
// -------+-----------------------------------------------------------
// TRACK  | nudge gain by TRACK_STEP when average leaves the dead band
// ATTACK | clip seen on the last strobe; gain cut by ATTACK_STEP
// HOLD   | gain frozen, counting down hold_cnt strobes before TRACK
module agc_gain_ctrl
    import agc_pkg::*;
#(
    parameter int               NBITS       = 16,
    parameter int               GBITS       = 8,
    parameter logic [NBITS-1:0] TARGET      = 16'h2000,
    parameter logic [NBITS-1:0] HYST        = 16'h0400,
    parameter logic [NBITS-1:0] CLIP_LEVEL  = 16'h7000,
    parameter int               ATTACK_STEP = 8,
    parameter int               TRACK_STEP  = 1,
    parameter int               HOLD_COUNT  = 64,
    parameter logic [GBITS-1:0] GAIN_INIT   = 8'h40,
    parameter logic [GBITS-1:0] GAIN_MIN    = 8'h01,
    parameter logic [GBITS-1:0] GAIN_MAX    = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             next,
    input  logic [NBITS-1:0] average,
    input  logic [NBITS-1:0] max_val,
    output logic [GBITS-1:0] gain,
    output logic             gain_valid,
    output logic             clip,
    output logic [1:0]       state_o
`ifdef AGC_CLIP_COUNT_EN
    ,
    output logic [CLIP_CNT_W-1:0] clip_count
`endif
);

    localparam logic [NBITS-1:0] BAND_HI   = NBITS'(band_hi(32'(TARGET), 32'(HYST)));
    localparam logic [NBITS-1:0] BAND_LO   = NBITS'(band_lo(32'(TARGET), 32'(HYST)));
    localparam logic [GBITS-1:0] ATK_STEP  = GBITS'(ATTACK_STEP);
    localparam logic [GBITS-1:0] TRK_STEP  = GBITS'(TRACK_STEP);
    localparam logic [15:0]      HOLD_INIT = 16'(HOLD_COUNT);

    agc_state_t       state;
    logic [15:0]      hold_cnt;
    logic             clip_hit;
    logic             above;
    logic             below;
    logic [GBITS-1:0] step_sel;
    logic [GBITS-1:0] step_res;

    assign clip_hit = (max_val >= CLIP_LEVEL);
    assign above    = (average > BAND_HI);
    assign below    = (average < BAND_LO);
    assign step_sel = clip_hit ? ATK_STEP : TRK_STEP;
    assign state_o  = state;

    agc_sat_step #(
        .GBITS (GBITS),
        .GMIN  (GAIN_MIN),
        .GMAX  (GAIN_MAX)
    ) u_sat_step (
        .gain   (gain),
        .step   (step_sel),
        .up     (!clip_hit && below),
        .result (step_res)
    );

    // Main FSM: state, gain, hold counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_TRACK;
            gain       <= GAIN_INIT;
            gain_valid <= 1'b0;
            clip       <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            gain_valid <= 1'b0;
            if (next) begin
                if (clip_hit) begin
                    state      <= ST_ATTACK;
                    clip       <= 1'b1;
                    gain       <= step_res;
                    gain_valid <= (step_res != gain);
                    hold_cnt   <= HOLD_INIT;
                end else begin
                    case (decode_state(state))
                        ST_ATTACK: begin
                            state <= ST_HOLD;
                            clip  <= 1'b0;
                        end
                        ST_HOLD: begin
                            if (hold_cnt <= 16'd1) begin
                                state    <= ST_TRACK;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt - 16'd1;
                            end
                        end
                        default: begin
                            state <= ST_TRACK;
                            clip  <= 1'b0;
                            if (above || below) begin
                                gain       <= step_res;
                                gain_valid <= (step_res != gain);
                            end
                        end
                    endcase
                end
            end
        end
    end

`ifdef AGC_CLIP_COUNT_EN
    // Count entries into ATTACK only; repeated clips while in ATTACK don't count.
    always_ff @(posedge clk) begin
        if (rst) begin
            clip_count <= '0;
        end else if (next && clip_hit && (state != ST_ATTACK) && (clip_count != '1)) begin
            clip_count <= clip_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Directed self-checking bench for agc_gain_ctrl (default parameters).
module tb_agc_gain_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        next = 1'b0;
    logic [15:0] average = 16'h2000;
    logic [15:0] max_val = 16'h0000;
    logic [7:0]  gain;
    logic        gain_valid;
    logic        clip;
    logic [1:0]  state_o;
`ifdef AGC_CLIP_COUNT_EN
    logic [15:0] clip_count;
`endif

    int checks = 0;
    int errors = 0;

    agc_gain_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .next       (next),
        .average    (average),
        .max_val    (max_val),
        .gain       (gain),
        .gain_valid (gain_valid),
        .clip       (clip),
        .state_o    (state_o)
`ifdef AGC_CLIP_COUNT_EN
        ,
        .clip_count (clip_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        next = 1'b0;
        average = 16'h2000;
        max_val = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One strobe; returns at the following falling edge with outputs updated.
    task automatic strobe(input logic [15:0] avg, input logic [15:0] mx);
        average = avg;
        max_val = mx;
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
    endtask

    task automatic test_reset();
        int pulses;
        do_reset();
        checks++;
        if (gain !== 8'h40) begin errors++; $display("FAIL reset_gain: got %h want 40", gain); end
        checks++;
        if (state_o !== 2'd0 || clip !== 1'b0 || gain_valid !== 1'b0) begin
            errors++; $display("FAIL reset_flags: state=%0d clip=%b valid=%b want 0 0 0", state_o, clip, gain_valid);
        end
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            average = 16'($urandom);
            max_val = 16'hFFFF;
            @(negedge clk);
            if (gain_valid === 1'b1) pulses++;
        end
        checks++;
        if (gain !== 8'h40 || state_o !== 2'd0 || pulses != 0) begin
            errors++; $display("FAIL idle_hold: gain=%h state=%0d pulses=%0d want 40 0 0", gain, state_o, pulses);
        end
    endtask

    task automatic test_track();
        int pulses;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            strobe(16'h1000, 16'h0000);
            checks++;
            if (gain !== 8'(8'h41 + i) || gain_valid !== 1'b1) begin
                errors++; $display("FAIL track_up_%0d: gain=%h valid=%b want %h 1", i, gain, gain_valid, 8'(8'h41 + i));
            end
            if (gain_valid === 1'b1) pulses++;
            @(negedge clk);
            if (gain_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 10) begin errors++; $display("FAIL track_pulses: got %0d want 10", pulses); end
        strobe(16'h2000, 16'h0000);
        checks++;
        if (gain !== 8'h4A || gain_valid !== 1'b0) begin
            errors++; $display("FAIL track_center: gain=%h valid=%b want 4a 0", gain, gain_valid);
        end
        strobe(16'h2400, 16'h0000);
        strobe(16'h1C00, 16'h0000);
        checks++;
        if (gain !== 8'h4A || gain_valid !== 1'b0) begin
            errors++; $display("FAIL band_edges: gain=%h valid=%b want 4a 0", gain, gain_valid);
        end
        strobe(16'h2401, 16'h0000);
        checks++;
        if (gain !== 8'h49 || gain_valid !== 1'b1) begin
            errors++; $display("FAIL above_band: gain=%h valid=%b want 49 1", gain, gain_valid);
        end
        strobe(16'h1BFF, 16'h6FFF);
        checks++;
        if (gain !== 8'h4A || state_o !== 2'd0 || clip !== 1'b0) begin
            errors++; $display("FAIL below_band_noclip: gain=%h state=%0d clip=%b want 4a 0 0", gain, state_o, clip);
        end
    endtask

    task automatic test_attack_hold();
        int bad;
        do_reset();
        strobe(16'h2000, 16'h7000);
        checks++;
        if (gain !== 8'h38 || clip !== 1'b1 || state_o !== 2'd1 || gain_valid !== 1'b1) begin
            errors++; $display("FAIL attack: gain=%h clip=%b state=%0d valid=%b want 38 1 1 1", gain, clip, state_o, gain_valid);
        end
        strobe(16'h0000, 16'h0000);
        checks++;
        if (state_o !== 2'd2 || clip !== 1'b0 || gain !== 8'h38) begin
            errors++; $display("FAIL enter_hold: state=%0d clip=%b gain=%h want 2 0 38", state_o, clip, gain);
        end
        bad = 0;
        for (int i = 0; i < 63; i++) begin
            strobe(16'h0000, 16'h0000);
            if (state_o !== 2'd2 || gain !== 8'h38 || gain_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL hold_frozen: %0d bad strobes want 0", bad); end
        strobe(16'h0000, 16'h0000);
        checks++;
        if (state_o !== 2'd0 || gain !== 8'h38) begin
            errors++; $display("FAIL hold_exit: state=%0d gain=%h want 0 38", state_o, gain);
        end
        strobe(16'h0000, 16'h0000);
        checks++;
        if (gain !== 8'h39 || state_o !== 2'd0) begin
            errors++; $display("FAIL track_after_hold: gain=%h state=%0d want 39 0", gain, state_o);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 59; i++) strobe(16'h3000, 16'h0000);
        checks++;
        if (gain !== 8'h05) begin errors++; $display("FAIL sat_setup_low: gain=%h want 05", gain); end
        strobe(16'h2000, 16'h8000);
        checks++;
        if (gain !== 8'h01 || gain_valid !== 1'b1) begin
            errors++; $display("FAIL sat_min_reach: gain=%h valid=%b want 01 1", gain, gain_valid);
        end
        strobe(16'h2000, 16'hFFFF);
        checks++;
        if (gain !== 8'h01 || gain_valid !== 1'b0 || state_o !== 2'd1) begin
            errors++; $display("FAIL sat_min_stay: gain=%h valid=%b state=%0d want 01 0 1", gain, gain_valid, state_o);
        end
`ifdef AGC_CLIP_COUNT_EN
        checks++;
        if (clip_count !== 16'd1) begin errors++; $display("FAIL clip_count_stay: got %0d want 1", clip_count); end
`endif
        do_reset();
        for (int i = 0; i < 190; i++) strobe(16'h0000, 16'h0000);
        checks++;
        if (gain !== 8'hFE) begin errors++; $display("FAIL sat_setup_high: gain=%h want fe", gain); end
        strobe(16'h0000, 16'h0000);
        checks++;
        if (gain !== 8'hFF || gain_valid !== 1'b1) begin
            errors++; $display("FAIL sat_max_reach: gain=%h valid=%b want ff 1", gain, gain_valid);
        end
        strobe(16'h0000, 16'h0000);
        checks++;
        if (gain !== 8'hFF || gain_valid !== 1'b0) begin
            errors++; $display("FAIL sat_max_stay: gain=%h valid=%b want ff 0", gain, gain_valid);
        end
    endtask

    task automatic test_clip_in_hold();
        int bad;
        do_reset();
        strobe(16'h2000, 16'h7000);
        strobe(16'h2000, 16'h0000);
        for (int i = 0; i < 29; i++) strobe(16'h2000, 16'h0000);
        checks++;
        if (state_o !== 2'd2 || gain !== 8'h38) begin
            errors++; $display("FAIL pre_reclip: state=%0d gain=%h want 2 38", state_o, gain);
        end
        strobe(16'h2000, 16'h7FFF);
        checks++;
        if (state_o !== 2'd1 || gain !== 8'h30 || clip !== 1'b1) begin
            errors++; $display("FAIL reclip: state=%0d gain=%h clip=%b want 1 30 1", state_o, gain, clip);
        end
`ifdef AGC_CLIP_COUNT_EN
        checks++;
        if (clip_count !== 16'd2) begin errors++; $display("FAIL clip_count_reclip: got %0d want 2", clip_count); end
`endif
        strobe(16'h2000, 16'h0000);
        bad = 0;
        for (int i = 0; i < 63; i++) begin
            strobe(16'h2000, 16'h0000);
            if (state_o !== 2'd2) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL hold_restart: %0d early exits want 0", bad); end
        strobe(16'h2000, 16'h0000);
        checks++;
        if (state_o !== 2'd0 || gain !== 8'h30) begin
            errors++; $display("FAIL hold_restart_exit: state=%0d gain=%h want 0 30", state_o, gain);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        average = 16'h1000;
        max_val = 16'h0000;
        next = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (gain !== 8'(8'h41 + i) || gain_valid !== 1'b1) begin
                errors++; $display("FAIL b2b_%0d: gain=%h valid=%b want %h 1", i, gain, gain_valid, 8'(8'h41 + i));
            end
        end
        next = 1'b0;
        @(negedge clk);
        checks++;
        if (gain !== 8'h43 || gain_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_end: gain=%h valid=%b want 43 0", gain, gain_valid);
        end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        for (int i = 0; i < 4; i++) strobe(16'h2000, 16'h7000);
        strobe(16'h2000, 16'h0000);
        checks++;
        if (gain !== 8'h20 || state_o !== 2'd2) begin
            errors++; $display("FAIL rst_hold_setup: gain=%h state=%0d want 20 2", gain, state_o);
        end
        rst = 1'b1;
        next = 1'b1;
        max_val = 16'hFFFF;
        @(negedge clk);
        rst = 1'b0;
        next = 1'b0;
        max_val = 16'h0000;
        checks++;
        if (gain !== 8'h40 || state_o !== 2'd0 || clip !== 1'b0 || gain_valid !== 1'b0) begin
            errors++; $display("FAIL rst_in_hold: gain=%h state=%0d clip=%b valid=%b want 40 0 0 0", gain, state_o, clip, gain_valid);
        end
`ifdef AGC_CLIP_COUNT_EN
        checks++;
        if (clip_count !== 16'd0) begin errors++; $display("FAIL clip_count_rst: got %0d want 0", clip_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_track();
        test_attack_hold();
        test_saturation();
        test_clip_in_hold();
        test_back_to_back();
        test_reset_in_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
